// File: rtl/tb_reorder_lifo.sv
// ---------------------------------------------------------------------------
// tb_reorder_lifo
//   Output re-ordering stage behind the Viterbi traceback unit. The TBU emits
//   decoded bits newest-first; they are collected into DEPTH-bit windows in
//   two ping-pong banks, and each completed window is drained last-written-
//   first so bits leave in forward time order over a valid/ready handshake.
//
// Parameters
//   DEPTH  bits per traceback window (bank size), 2..256
//   AW     bank address width, derived from DEPTH
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   enable     in   low = synchronous clear of all control state
//   wr_en      in   write strobe from TBU
//   d_in       in   decoded bit from TBU, qualified by wr_en
//   out_ready  in   sink accepts d_out this cycle
//   d_out      out  decoded bit, forward order (registered)
//   d_valid    out  d_out holds a valid bit (registered)
//   overrun    out  sticky: a window was truncated (registered)
//   wr_bank    out  bank currently being filled (status)
// ---------------------------------------------------------------------------
module tb_reorder_lifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic wr_en,
    input  logic d_in,
    input  logic out_ready,
    output logic d_out,
    output logic d_valid,
    output logic overrun,
    output logic wr_bank
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_mem [2][DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] w_wr_ptr_nxt;
    logic          w_wr_bank_nxt;

    logic [AW-1:0] r_rd_ptr;      // address of the bit currently on d_out
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [AW-1:0] w_rd_ptr_dec;
    logic          r_rd_bank;
    logic          w_rd_bank_nxt;

    logic          w_d_out_nxt;
    logic          w_d_valid_nxt;
    logic          w_overrun_nxt;

    logic          w_wr;
    logic          w_fill;
    logic          w_xfer;
    logic          w_last_xfer;

    assign w_wr         = enable & wr_en;
    assign w_fill       = w_wr & (r_wr_ptr == LAST);
    assign w_xfer       = d_valid & out_ready;
    assign w_last_xfer  = w_xfer & (r_rd_ptr == '0);
    assign w_rd_ptr_dec = r_rd_ptr - AW'(1);

    // Bank storage: no reset, written only while enabled.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[wr_bank][r_wr_ptr] <= d_in;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_wr_bank_nxt = wr_bank;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_rd_bank_nxt = r_rd_bank;
        w_d_out_nxt   = d_out;
        w_d_valid_nxt = d_valid;
        w_overrun_nxt = overrun;

        if (!enable) begin
            w_state_nxt   = S_IDLE;
            w_wr_ptr_nxt  = '0;
            w_wr_bank_nxt = 1'b0;
            w_rd_ptr_nxt  = '0;
            w_rd_bank_nxt = 1'b0;
            w_d_out_nxt   = 1'b0;
            w_d_valid_nxt = 1'b0;
            w_overrun_nxt = 1'b0;
        end else begin
            if (w_wr) begin
                w_wr_ptr_nxt = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + AW'(1);
            end

            if (w_fill) begin
                // The completing bit is not in the bank yet on this edge,
                // so it is taken straight from d_in onto the output.
                w_wr_bank_nxt = ~wr_bank;
                w_rd_bank_nxt = wr_bank;
                w_rd_ptr_nxt  = LAST;
                w_d_out_nxt   = d_in;
                w_d_valid_nxt = 1'b1;
                w_state_nxt   = S_DRAIN;
                // Bits still pending in the old window are abandoned,
                // unless its final bit is transferring on this same edge.
                if ((r_state == S_DRAIN) && !w_last_xfer) begin
                    w_overrun_nxt = 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_d_valid_nxt = 1'b0;
                    end
                    S_DRAIN: begin
                        if (w_xfer) begin
                            if (r_rd_ptr == '0) begin
                                w_state_nxt   = S_IDLE;
                                w_d_valid_nxt = 1'b0;
                            end else begin
                                w_rd_ptr_nxt = w_rd_ptr_dec;
                                w_d_out_nxt  = r_mem[r_rd_bank][w_rd_ptr_dec];
                            end
                        end
                    end
                    default: begin
                        w_state_nxt   = S_IDLE;
                        w_d_valid_nxt = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            wr_bank   <= 1'b0;
            r_rd_ptr  <= '0;
            r_rd_bank <= 1'b0;
            d_out     <= 1'b0;
            d_valid   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_ptr  <= w_wr_ptr_nxt;
            wr_bank   <= w_wr_bank_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            d_out     <= w_d_out_nxt;
            d_valid   <= w_d_valid_nxt;
            overrun   <= w_overrun_nxt;
        end
    end

endmodule

// File: tb/tb_tb_reorder_lifo.sv
// ---------------------------------------------------------------------------
// tb_tb_reorder_lifo
//   Scoreboard bench for tb_reorder_lifo (DEPTH=8). Each completed window
//   pushes its reversed bits to an expected queue; accepted outputs pop it.
// ---------------------------------------------------------------------------
module tb_tb_reorder_lifo;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic wr_en = 1'b0;
    logic d_in = 1'b0;
    logic out_ready = 1'b0;
    logic d_out;
    logic d_valid;
    logic overrun;
    logic wr_bank;

    always #5 clk = ~clk;

    tb_reorder_lifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .wr_en     (wr_en),
        .d_in      (d_in),
        .out_ready (out_ready),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .overrun   (overrun),
        .wr_bank   (wr_bank)
    );

    logic        q[$];
    logic        win[DEPTH];
    int unsigned m_ptr;
    logic        m_bank;
    logic        m_ov;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ptr  = 0;
        m_bank = 1'b0;
        m_ov   = 1'b0;
    endtask

    task automatic check_state();
        chk("d_valid", d_valid, q.size() != 0);
        if (q.size() != 0) chk("d_out_shown", d_out, q[0]);
        chk("overrun", overrun, m_ov);
        chk("wr_bank", wr_bank, m_bank);
    endtask

    // One clock: inputs are applied 1 time unit after the previous edge,
    // the model advances with the same edge, and outputs are checked after.
    task automatic cyc(input logic we, input logic d, input logic rdy);
        wr_en     = we;
        d_in      = d;
        out_ready = rdy;
        if (d_valid && rdy) begin
            if (q.size() == 0) begin
                chk("spurious_out", d_valid, 1'b0);
            end else begin
                chk("d_out_xfer", d_out, q[0]);
                void'(q.pop_front());
            end
        end
        if (we) begin
            win[m_ptr] = d;
            if (m_ptr == DEPTH - 1) begin
                if (q.size() != 0) m_ov = 1'b1;
                q.delete();
                for (int i = DEPTH - 1; i >= 0; i--) q.push_back(win[i]);
                m_ptr  = 0;
                m_bank = ~m_bank;
            end else begin
                m_ptr++;
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    logic [DEPTH-1:0] pat1;
    logic [DEPTH-1:0] pat2;

    initial begin
        pat1 = 8'b1000_1101;  // LSB first: 1,0,1,1,0,0,0,1
        pat2 = 8'b1000_0000;  // LSB first: 0,0,0,0,0,0,0,1
        model_clear();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d_valid", d_valid, 1'b0);
        chk("rst_d_out", d_out, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_wr_bank", wr_bank, 1'b0);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;

        // single window, free-flowing sink; expected out 1,0,0,0,1,1,0,1
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, pat1[i], 1'b1);
        chk("t1_first_bit", d_out, 1'b1);
        drain(DEPTH + 2);

        // 24 continuous writes: seamless hand-off between windows
        for (int i = 0; i < 3 * DEPTH; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        drain(DEPTH + 2);

        // backpressure after the 2nd bit is presented
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, pat1[i], 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("bp_hold_out", d_out, 1'b0);
        end
        drain(DEPTH + 2);

        // overrun: sink stalled across two fills
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, pat1[i], 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, pat2[i], 1'b0);
        chk("ov_flag", overrun, 1'b1);
        chk("ov_first_bit", d_out, 1'b1);
        drain(3);

        // asynchronous reset mid-drain
        #3;
        rst = 1'b0;
        #1;
        chk("arst_d_valid", d_valid, 1'b0);
        chk("arst_d_out", d_out, 1'b0);
        chk("arst_overrun", overrun, 1'b0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_wr_bank", wr_bank, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, pat1[i], 1'b1);
        drain(DEPTH + 2);

        // enable drop after 5 writes discards the partial window
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1);
        enable = 1'b0;
        wr_en  = 1'b1;
        d_in   = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        check_state();
        enable = 1'b1;
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'(i % 2 == 0), 1'b1);
        chk("en_first_bit", d_out, 1'b0);
        drain(DEPTH + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
